// File: rtl/ctrl_sequencer_if.sv
// rtl/ctrl_sequencer_if.sv - instruction handshake and datapath control bus of the sequencer
interface ctrl_sequencer_if #(
    parameter int CNT_W = 4
);
    logic [8+CNT_W-1:0] instr;
    logic               instr_valid;
    logic               instr_ready;
    logic [7:0]         ctrl_bus;
    logic               busy;
    logic               op_last;

    modport master (
        output instr, instr_valid,
        input  instr_ready, ctrl_bus, busy, op_last
    );

    modport slave (
        input  instr, instr_valid,
        output instr_ready, ctrl_bus, busy, op_last
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// rtl/ctrl_sequencer.sv - expands macro-instructions into per-cycle datapath control words
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates every RUN advance.
module ctrl_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    ctrl_sequencer_if.slave     bus
);
    typedef enum logic { IDLE = 1'b0, RUN = 1'b1 } state_t;
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'b00,
        MODE_ACCUM  = 2'b01,
        MODE_HOLD   = 2'b10,
        MODE_LOADR  = 2'b11
    } mode_t;

`ifndef SEQ_SINGLE_STEP_EN
    logic step;
    assign step = 1'b1;
`endif

    state_t             state, state_nxt;
    mode_t              mode_q, mode_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic [2:0]         alu_q, alu_nxt;
    logic [1:0]         shift_q, shift_nxt;
    logic               src_q, src_nxt;
    logic               first_q, first_nxt;
    logic               last;
    logic               accept;
    logic [7:0]         word;

    assign last            = (state == RUN) && (counter == '0);
    assign bus.op_last     = last;
    assign bus.busy        = (state == RUN);
    assign bus.instr_ready = (state == IDLE) | (last & step);
    assign accept          = bus.instr_valid & bus.instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mode_q  <= MODE_SINGLE;
            counter <= '0;
            alu_q   <= 3'd0;
            shift_q <= 2'd0;
            src_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            mode_q  <= mode_nxt;
            counter <= counter_nxt;
            alu_q   <= alu_nxt;
            shift_q <= shift_nxt;
            src_q   <= src_nxt;
            first_q <= first_nxt;
        end
    end

    // An accept while on the last word overrides the retire, giving back-to-back issue.
    always_comb begin
        state_nxt   = state;
        mode_nxt    = mode_q;
        counter_nxt = counter;
        alu_nxt     = alu_q;
        shift_nxt   = shift_q;
        src_nxt     = src_q;
        first_nxt   = first_q;
        if (accept) begin
            state_nxt = RUN;
            mode_nxt  = mode_t'(bus.instr[7:6]);
            alu_nxt   = bus.instr[2:0];
            src_nxt   = bus.instr[3];
            shift_nxt = bus.instr[5:4];
            first_nxt = 1'b1;
            if ((bus.instr[7:6] == MODE_ACCUM) || (bus.instr[7:6] == MODE_HOLD))
                counter_nxt = bus.instr[8+CNT_W-1:8];
            else
                counter_nxt = '0;
        end else if ((state == RUN) && step) begin
            if (counter == '0) begin
                state_nxt = IDLE;
            end else begin
                counter_nxt = counter - CNT_W'(1);
                first_nxt   = 1'b0;
            end
        end
    end

    // ACCUM takes B on its first word, R feedback afterwards, and loads Q on the last word.
    always_comb begin
        word = 8'h00;
        case (mode_q)
            MODE_SINGLE: word = {2'b11, shift_q, src_q, alu_q};
            MODE_ACCUM:  word = {1'b1, last, shift_q, ~first_q, alu_q};
            MODE_HOLD:   word = 8'h00;
            MODE_LOADR:  word = {2'b10, shift_q, src_q, alu_q};
            default:     word = 8'h00;
        endcase
    end

    assign bus.ctrl_bus = ((state == RUN) && step) ? word : 8'h00;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb/tb_ctrl_sequencer.sv - directed self-checking bench for ctrl_sequencer
module tb_ctrl_sequencer;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b1;
`endif
    int checks = 0;
    int errors = 0;

    ctrl_sequencer_if #(.CNT_W(CNT_W)) bus ();

    ctrl_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SEQ_SINGLE_STEP_EN
        .step  (step),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        tick();
        tick();
        checks++; if (bus.ctrl_bus !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", bus.ctrl_bus); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.op_last !== 1'b0) begin errors++; $display("FAIL reset_op_last got %b want 0", bus.op_last); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.instr_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.instr = 12'h005;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        checks++; if (bus.ctrl_bus !== 8'hC5) begin errors++; $display("FAIL single_word got %h want c5", bus.ctrl_bus); end
        checks++; if (bus.op_last !== 1'b1) begin errors++; $display("FAIL single_op_last got %b want 1", bus.op_last); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", bus.busy); end
        tick();
        checks++; if (bus.ctrl_bus !== 8'h00) begin errors++; $display("FAIL single_after got %h want 00", bus.ctrl_bus); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_accum();
        logic [7:0] exp_w [4];
        exp_w[0] = 8'h91; exp_w[1] = 8'h99; exp_w[2] = 8'h99; exp_w[3] = 8'hD9;
        bus.instr = 12'h351;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.instr_valid = 1'b0;
            checks++; if (bus.ctrl_bus !== exp_w[i]) begin errors++; $display("FAIL accum_word%0d got %h want %h", i, bus.ctrl_bus, exp_w[i]); end
            checks++; if (bus.op_last !== (i == 3)) begin errors++; $display("FAIL accum_op_last%0d got %b want %b", i, bus.op_last, (i == 3)); end
            checks++; if (bus.instr_ready !== (i == 3)) begin errors++; $display("FAIL accum_ready%0d got %b want %b", i, bus.instr_ready, (i == 3)); end
        end
        tick();
        checks++; if (bus.ctrl_bus !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL accum_retire got %h/%b want 00/0", bus.ctrl_bus, bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] vin [3];
        logic [7:0]  vexp [3];
        vin[0] = 12'h005; vexp[0] = 8'hC5;
        vin[1] = 12'h013; vexp[1] = 8'hD3;
        vin[2] = 12'h02E; vexp[2] = 8'hEE;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instr = vin[i];
            tick();
            checks++; if (bus.ctrl_bus !== vexp[i]) begin errors++; $display("FAIL b2b_word%0d got %h want %h", i, bus.ctrl_bus, vexp[i]); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d got %b want 1", i, bus.busy); end
        end
        bus.instr_valid = 1'b0;
        tick();
        checks++; if (bus.ctrl_bus !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_retire got %h/%b want 00/0", bus.ctrl_bus, bus.busy); end
    endtask

    task automatic test_hold_loadr();
        bus.instr = 12'h280;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr = 12'h0CA;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.ctrl_bus !== 8'h00 || bus.busy !== 1'b1) begin errors++; $display("FAIL hold_word%0d got %h/%b want 00/1", i, bus.ctrl_bus, bus.busy); end
            checks++; if (bus.instr_ready !== (i == 2)) begin errors++; $display("FAIL hold_ready%0d got %b want %b", i, bus.instr_ready, (i == 2)); end
            tick();
        end
        bus.instr_valid = 1'b0;
        checks++; if (bus.ctrl_bus !== 8'h8A) begin errors++; $display("FAIL loadr_word got %h want 8a", bus.ctrl_bus); end
        checks++; if (bus.op_last !== 1'b1) begin errors++; $display("FAIL loadr_op_last got %b want 1", bus.op_last); end
        tick();
        checks++; if (bus.ctrl_bus !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL loadr_retire got %h/%b want 00/0", bus.ctrl_bus, bus.busy); end
    endtask

    task automatic test_reset_mid_op();
        bus.instr = 12'h551;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        checks++; if (bus.ctrl_bus !== 8'h91) begin errors++; $display("FAIL rmid_word0 got %h want 91", bus.ctrl_bus); end
        tick();
        tick();
        checks++; if (bus.ctrl_bus !== 8'h99) begin errors++; $display("FAIL rmid_word2 got %h want 99", bus.ctrl_bus); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.ctrl_bus !== 8'h00) begin errors++; $display("FAIL rmid_ctrl got %h want 00", bus.ctrl_bus); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", bus.instr_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.ctrl_bus !== 8'h00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_quiet%0d got %h/%b want 00/0", i, bus.ctrl_bus, bus.busy); end
        end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    task automatic test_single_step();
        int live;
        logic [7:0] exp_live [2];
        exp_live[0] = 8'h91; exp_live[1] = 8'hD9;
        live = 0;
        step = 1'b0;
        bus.instr = 12'h151;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step = ((i % 3) == 2);
            #1;
            if (step) begin
                checks++; if (bus.ctrl_bus !== exp_live[live]) begin errors++; $display("FAIL step_live%0d got %h want %h", live, bus.ctrl_bus, exp_live[live]); end
                checks++; if (bus.op_last !== (live == 1)) begin errors++; $display("FAIL step_op_last%0d got %b want %b", live, bus.op_last, (live == 1)); end
                live++;
            end else begin
                checks++; if (bus.ctrl_bus !== 8'h00 || bus.busy !== 1'b1) begin errors++; $display("FAIL step_hold%0d got %h/%b want 00/1", i, bus.ctrl_bus, bus.busy); end
            end
            tick();
        end
        step = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.ctrl_bus !== 8'h00) begin errors++; $display("FAIL step_retire got %h/%b want 00/0", bus.ctrl_bus, bus.busy); end
        step = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_accum();
        test_back_to_back();
        test_hold_loadr();
        test_reset_mid_op();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
